// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared branch codes, ALU constants and the ID->EX control bundle
package cpu_pkg;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEZ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  localparam logic [3:0] ALU_NOP = 4'b0000;

  typedef struct packed {
    logic [3:0] alu_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       is_imm;
    logic [1:0] branch_type;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_branch_eval.sv
// rtl/id_ex_stage_branch_eval.sv - combinational branch condition and target evaluation
import cpu_pkg::*;

module branch_eval #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic [1:0]        branch_type,
  input  logic [DATA_W-1:0] val1,
  input  logic [DATA_W-1:0] val2,
  input  logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] imm,
  output logic              cond,
  output logic [PC_W-1:0]   target
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  logic [PC_W-1:0] imm_ext;

  // Branch condition from the branch code; the immediate is word-scaled and wraps
  always_comb begin
    imm_ext = PC_W'($signed(imm));
    target  = pc + PC_STEP + (imm_ext << 2);
    case (branch_type)
      BR_BEZ:  cond = (val1 == '0);
      BR_BNE:  cond = (val1 != val2);
      BR_JMP:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID->EX pipeline register with load-use stall and branch redirect (option: ID_EX_PERF_CNT_EN)
import cpu_pkg::*;

module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_alu_cmd,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_wb_en,
  input  logic              in_is_imm,
  input  logic [1:0]        in_branch_type,
  input  logic [REG_AW-1:0] in_src1,
  input  logic [REG_AW-1:0] in_src2,
  input  logic [REG_AW-1:0] in_dest,
  input  logic [DATA_W-1:0] in_val1,
  input  logic [DATA_W-1:0] in_val2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              out_ready,
  output logic              ex_valid,
  output logic [3:0]        ex_alu_cmd,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_wb_en,
  output logic [REG_AW-1:0] ex_dest,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              br_taken,
  output logic [PC_W-1:0]   br_target
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stalls,
  output logic [31:0]       perf_br_taken
`endif
);

  // Registered state not visible on the EX interface, kept for branch evaluation
  logic [1:0]        ex_branch_type;
  logic [DATA_W-1:0] ex_imm;
  logic [PC_W-1:0]   ex_pc;

  ctrl_t             cap_ctrl;
  logic              advance;
  logic              hazard;
  logic              br_cond;
  logic [PC_W-1:0]   br_tgt_raw;

  // Scrub the incoming control bundle: branches carry no ALU/memory/writeback work,
  // and writes to the zero register are dropped
  always_comb begin
    cap_ctrl.alu_cmd     = in_alu_cmd;
    cap_ctrl.mem_read    = in_mem_read;
    cap_ctrl.mem_write   = in_mem_write;
    cap_ctrl.wb_en       = in_wb_en;
    cap_ctrl.is_imm      = in_is_imm;
    cap_ctrl.branch_type = in_branch_type;
    if (in_branch_type != BR_NONE) begin
      cap_ctrl.alu_cmd   = ALU_NOP;
      cap_ctrl.mem_read  = 1'b0;
      cap_ctrl.mem_write = 1'b0;
      cap_ctrl.wb_en     = 1'b0;
    end
    if (in_dest == '0) begin
      cap_ctrl.wb_en = 1'b0;
    end
  end

  // Handshake: a stalled load keeps its hazard live, so the consumer is held, not re-bubbled
  always_comb begin
    advance  = out_ready | ~ex_valid;
    hazard   = ex_valid & ex_mem_read & ex_wb_en & (ex_dest != '0) & in_valid &
               ((in_src1 == ex_dest) |
                ((~in_is_imm | in_mem_write) & (in_src2 == ex_dest)));
    in_ready = advance & ~hazard;
  end

  branch_eval #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W)
  ) u_branch_eval (
    .branch_type (ex_branch_type),
    .val1        (ex_op_a),
    .val2        (ex_store_data),
    .pc          (ex_pc),
    .imm         (ex_imm),
    .cond        (br_cond),
    .target      (br_tgt_raw)
  );

  // Redirect fires only when the branch actually leaves EX; target is zeroed otherwise
  always_comb begin
    br_taken  = ex_valid & out_ready & br_cond;
    br_target = br_taken ? br_tgt_raw : '0;
  end

  // EX slot register: bubble on redirect, hazard or empty input, else capture from ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid       <= 1'b0;
      ex_alu_cmd     <= ALU_NOP;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_wb_en       <= 1'b0;
      ex_branch_type <= BR_NONE;
      ex_dest        <= '0;
      ex_op_a        <= '0;
      ex_op_b        <= '0;
      ex_store_data  <= '0;
      ex_imm         <= '0;
      ex_pc          <= '0;
    end else if (advance) begin
      if (br_taken || hazard || !in_valid) begin
        ex_valid       <= 1'b0;
        ex_alu_cmd     <= ALU_NOP;
        ex_mem_read    <= 1'b0;
        ex_mem_write   <= 1'b0;
        ex_wb_en       <= 1'b0;
        ex_branch_type <= BR_NONE;
        ex_dest        <= '0;
        ex_op_a        <= '0;
        ex_op_b        <= '0;
        ex_store_data  <= '0;
        ex_imm         <= '0;
        ex_pc          <= '0;
      end else begin
        ex_valid       <= 1'b1;
        ex_alu_cmd     <= cap_ctrl.alu_cmd;
        ex_mem_read    <= cap_ctrl.mem_read;
        ex_mem_write   <= cap_ctrl.mem_write;
        ex_wb_en       <= cap_ctrl.wb_en;
        ex_branch_type <= cap_ctrl.branch_type;
        ex_dest        <= in_dest;
        ex_op_a        <= in_val1;
        ex_op_b        <= (cap_ctrl.is_imm | cap_ctrl.mem_read | cap_ctrl.mem_write) ?
                          in_imm : in_val2;
        ex_store_data  <= in_val2;
        ex_imm         <= in_imm;
        ex_pc          <= in_pc;
      end
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  // Saturating event counters for load-use stall cycles and taken redirects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stalls   <= '0;
      perf_br_taken <= '0;
    end else begin
      if (hazard && advance && (perf_stalls != '1)) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
      if (br_taken && (perf_br_taken != '1)) begin
        perf_br_taken <= perf_br_taken + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_alu_cmd;
  logic        in_mem_read;
  logic        in_mem_write;
  logic        in_wb_en;
  logic        in_is_imm;
  logic [1:0]  in_branch_type;
  logic [4:0]  in_src1;
  logic [4:0]  in_src2;
  logic [4:0]  in_dest;
  logic [31:0] in_val1;
  logic [31:0] in_val2;
  logic [31:0] in_imm;
  logic [31:0] in_pc;
  logic        out_ready;
  logic        ex_valid;
  logic [3:0]  ex_alu_cmd;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_wb_en;
  logic [4:0]  ex_dest;
  logic [31:0] ex_op_a;
  logic [31:0] ex_op_b;
  logic [31:0] ex_store_data;
  logic        br_taken;
  logic [31:0] br_target;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_stalls;
  logic [31:0] perf_br_taken;
`endif

  int tests_run;
  int tests_failed;

  id_ex_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_alu_cmd     (in_alu_cmd),
    .in_mem_read    (in_mem_read),
    .in_mem_write   (in_mem_write),
    .in_wb_en       (in_wb_en),
    .in_is_imm      (in_is_imm),
    .in_branch_type (in_branch_type),
    .in_src1        (in_src1),
    .in_src2        (in_src2),
    .in_dest        (in_dest),
    .in_val1        (in_val1),
    .in_val2        (in_val2),
    .in_imm         (in_imm),
    .in_pc          (in_pc),
    .out_ready      (out_ready),
    .ex_valid       (ex_valid),
    .ex_alu_cmd     (ex_alu_cmd),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_wb_en       (ex_wb_en),
    .ex_dest        (ex_dest),
    .ex_op_a        (ex_op_a),
    .ex_op_b        (ex_op_b),
    .ex_store_data  (ex_store_data),
    .br_taken       (br_taken),
    .br_target      (br_target)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .perf_stalls    (perf_stalls),
    .perf_br_taken  (perf_br_taken)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] alu, input logic mr, input logic mw, input logic wb,
                       input logic imf, input logic [1:0] bt, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [4:0] d, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [31:0] im, input logic [31:0] pc);
    in_valid       = 1'b1;
    in_alu_cmd     = alu;
    in_mem_read    = mr;
    in_mem_write   = mw;
    in_wb_en       = wb;
    in_is_imm      = imf;
    in_branch_type = bt;
    in_src1        = s1;
    in_src2        = s2;
    in_dest        = d;
    in_val1        = v1;
    in_val2        = v2;
    in_imm         = im;
    in_pc          = pc;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    out_ready    = 1'b1;
    // ADD-immediate held on the input through reset
    drive(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 5'd1, 5'd2, 5'd4, 32'd5, 32'd9, 32'd3, 32'h0);
    tick();
    tick();
    check("rst_ex_valid", 64'(ex_valid), 64'd0);
    check("rst_br_taken", 64'(br_taken), 64'd0);
    check("rst_op_a", 64'(ex_op_a), 64'd0);
    check("rst_br_target", 64'(br_target), 64'd0);

    rst_n = 1'b1;
    #1;
    check("add_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("add_ex_valid", 64'(ex_valid), 64'd1);
    check("add_op_a", 64'(ex_op_a), 64'd5);
    check("add_op_b", 64'(ex_op_b), 64'd3);
    check("add_wb_en", 64'(ex_wb_en), 64'd1);
    check("add_dest", 64'(ex_dest), 64'd4);
    check("add_store_data", 64'(ex_store_data), 64'd9);

    // Load r7, then an ADD reading r7
    drive(4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 5'd2, 5'd3, 5'd7, 32'd100, 32'd0, 32'd8, 32'h10);
    tick();
    check("ld_mem_read", 64'(ex_mem_read), 64'd1);
    check("ld_op_b", 64'(ex_op_b), 64'd8);
    drive(4'h1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 5'd7, 5'd0, 5'd9, 32'd11, 32'd0, 32'd1, 32'h14);
    #1;
    check("lu_in_ready_stall", 64'(in_ready), 64'd0);
    tick();
    check("lu_bubble", 64'(ex_valid), 64'd0);
    check("lu_bubble_ctrl", 64'({ex_mem_read, ex_wb_en}), 64'd0);
    check("lu_in_ready_free", 64'(in_ready), 64'd1);
    tick();
    check("lu_add_valid", 64'(ex_valid), 64'd1);
    check("lu_add_dest", 64'(ex_dest), 64'd9);
    check("lu_add_op_a", 64'(ex_op_a), 64'd11);
    check("lu_add_alu", 64'(ex_alu_cmd), 64'd1);
`ifdef ID_EX_PERF_CNT_EN
    check("perf_stalls", 64'(perf_stalls), 64'd1);
`endif

    // BNE taken with a junk ALU command that must be scrubbed
    drive(4'hf, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'h10, 32'h100);
    tick();
    check("bne_valid", 64'(ex_valid), 64'd1);
    check("bne_alu_scrub", 64'(ex_alu_cmd), 64'd0);
    check("bne_ctrl_scrub", 64'({ex_mem_read, ex_mem_write, ex_wb_en}), 64'd0);
    check("bne_taken", 64'(br_taken), 64'd1);
    check("bne_target", 64'(br_target), 64'h144);
    drive(4'h2, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 5'd1, 5'd1, 5'd5, 32'd50, 32'd0, 32'd1, 32'h104);
    #1;
    check("bne_shadow_ready", 64'(in_ready), 64'd1);
    tick();
    check("bne_shadow_discard", 64'(ex_valid), 64'd0);
    check("bne_pulse_end", 64'(br_taken), 64'd0);

    // BEZ not taken, then a normal instruction follows
    drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 5'd1, 5'd2, 5'd0, 32'd3, 32'd0, 32'd4, 32'h200);
    tick();
    check("bez_valid", 64'(ex_valid), 64'd1);
    check("bez_not_taken", 64'(br_taken), 64'd0);
    check("bez_target_zero", 64'(br_target), 64'd0);
    drive(4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 5'd1, 5'd2, 5'd6, 32'd7, 32'd0, 32'd2, 32'h204);
    #1;
    check("bez_next_ready", 64'(in_ready), 64'd1);
    tick();
    check("bez_next_valid", 64'(ex_valid), 64'd1);
    check("bez_next_op_a", 64'(ex_op_a), 64'd7);
    check("bez_next_dest", 64'(ex_dest), 64'd6);

    // Writeback to r0 is dropped; register-register op uses val2 as operand B
    drive(4'h4, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd1, 5'd2, 5'd0, 32'd1, 32'd77, 32'd5, 32'h208);
    tick();
    check("r0_wb_drop", 64'(ex_wb_en), 64'd0);
    check("rr_op_b", 64'(ex_op_b), 64'd77);

    // JMP with imm=-1 wraps back to its own PC; MEM back-pressures for 3 cycles
    drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 5'd0, 5'd0, 5'd0, 32'h33, 32'd0, 32'hffff_ffff, 32'h300);
    tick();
    out_ready = 1'b0;
    drive(4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 5'd1, 5'd1, 5'd8, 32'd9, 32'd0, 32'd1, 32'h304);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_br_taken", 64'(br_taken), 64'd0);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      tick();
      check("bp_held_valid", 64'(ex_valid), 64'd1);
      check("bp_held_op_a", 64'(ex_op_a), 64'h33);
    end
    out_ready = 1'b1;
    #1;
    check("jmp_taken", 64'(br_taken), 64'd1);
    check("jmp_target_wrap", 64'(br_target), 64'h300);
    tick();
    check("jmp_pulse_once", 64'(br_taken), 64'd0);
    check("jmp_shadow_discard", 64'(ex_valid), 64'd0);
`ifdef ID_EX_PERF_CNT_EN
    check("perf_br_taken", 64'(perf_br_taken), 64'd2);
    check("perf_stalls_final", 64'(perf_stalls), 64'd1);
`endif

    in_valid = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
